mu0_reg16_serial_out: RTL and testbench

MU0_REG16_SERIAL_OUT -- requirements
Module: mu0_reg16_serial_out

---
 rtl/mu0_pkg.sv | 21 ++
 rtl/mu0_bit_timer.sv | 38 +++
 rtl/mu0_reg16_serial_out.sv | 129 ++++++++++++
 tb/tb_mu0_reg16_serial_out.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mu0_pkg.sv
// Shared definitions for the MU0 serial output block.
//   mu0_state_t : transmitter FSM state encoding
//   MU0_WIDTH   : default data word width
//   MU0_DIV     : default clocks per serial bit
//   cnt_width() : counter width for a modulus n, never less than one bit
package mu0_pkg;

    localparam int MU0_WIDTH = 16;
    localparam int MU0_DIV   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } mu0_state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mu0_bit_timer.sv
// Divide counter that sets the serial bit period.
//   Clk     : clock
//   Reset_n : asynchronous active-low reset
//   Enable  : count while high
//   Clear   : synchronous return to zero, wins over Enable
//   Tick    : high during the last clock of each bit period (count == DIV-1)
module mu0_bit_timer
    import mu0_pkg::*;
#(
    parameter int DIV = MU0_DIV
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic Enable,
    input  logic Clear,
    output logic Tick
);

    localparam int            CW = cnt_width(DIV);
    localparam logic [CW-1:0] TC = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt <= '0;
        end else if (Clear) begin
            cnt <= '0;
        end else if (Enable) begin
            // Wrap on the terminal count so the counter never leaves 0..DIV-1.
            cnt <= (cnt == TC) ? '0 : cnt + CW'(1);
        end
    end

    // With DIV=1 the count is stuck at 0 == TC, so Tick fires every enabled cycle.
    assign Tick = Enable && (cnt == TC);

endmodule

// File: rtl/mu0_reg16_serial_out.sv
// Parallel-in, serial-out transmitter with a valid/ready capture port.
//   Clk      : clock, all state changes on its rising edge
//   Reset_n  : asynchronous active-low reset
//   In_valid : producer offers a word on D
//   In_ready : block can accept a word (decoded from the state register)
//   D        : parallel word to send
//   SDO      : serial data out (registered)
//   Frame    : high while bits are on SDO (registered)
//   Done     : one-cycle pulse after the last bit (registered)
//
// state | meaning
// IDLE  | waiting for In_valid; In_ready high, outputs low
// SHIFT | word on SDO, one bit every DIV clocks
// DONE  | single-cycle Done pulse, then back to IDLE
module mu0_reg16_serial_out
    import mu0_pkg::*;
#(
    parameter int WIDTH     = MU0_WIDTH,
    parameter int DIV       = MU0_DIV,
    parameter int MSB_FIRST = 1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [WIDTH-1:0] D,
    output logic             SDO,
    output logic             Frame,
    output logic             Done
);

    localparam int            BW       = cnt_width(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    mu0_state_t       state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [BW-1:0]    bit_cnt, bit_nxt;
    logic             sdo_nxt, frame_nxt, done_nxt;
    logic             capture, tick;

    // The bit about to go out always sits at the leading end of the shift register.
    function automatic logic lead_bit(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
    endfunction

    mu0_bit_timer #(
        .DIV (DIV)
    ) u_bit_timer (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Enable  (state == SHIFT),
        .Clear   (capture),
        .Tick    (tick)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            SDO     <= 1'b0;
            Frame   <= 1'b0;
            Done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_nxt;
            SDO     <= sdo_nxt;
            Frame   <= frame_nxt;
            Done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        bit_nxt   = bit_cnt;
        sdo_nxt   = SDO;
        frame_nxt = Frame;
        done_nxt  = 1'b0;
        capture   = 1'b0;

        case (state)
            IDLE: begin
                sdo_nxt   = 1'b0;
                frame_nxt = 1'b0;
                if (In_valid) begin
                    capture   = 1'b1;
                    shreg_nxt = D;
                    bit_nxt   = '0;
                    sdo_nxt   = lead_bit(D);
                    frame_nxt = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        sdo_nxt   = 1'b0;
                        frame_nxt = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        shreg_nxt = shift_word(shreg);
                        sdo_nxt   = lead_bit(shift_word(shreg));
                        bit_nxt   = bit_cnt + BW'(1);
                    end
                end
            end
            DONE: begin
                sdo_nxt   = 1'b0;
                frame_nxt = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                sdo_nxt   = 1'b0;
                frame_nxt = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign In_ready = (state == IDLE);

endmodule

// File: tb/tb_mu0_reg16_serial_out.sv
// Directed bench for mu0_reg16_serial_out: default build plus DIV=1 and
// LSB-first DIV=2 variants, all sharing one clock and reset.
module tb_mu0_reg16_serial_out;

    logic Clk = 1'b0;
    logic Reset_n;

    logic        in_valid0, in_ready0, sdo0, frame0, done0;
    logic [15:0] d0;
    logic        in_valid1, in_ready1, sdo1, frame1, done1;
    logic [15:0] d1;
    logic        in_valid2, in_ready2, sdo2, frame2, done2;
    logic [15:0] d2;

    int n_pass  = 0;
    int n_total = 0;

    always #5 Clk = ~Clk;

    mu0_reg16_serial_out dut0 (
        .Clk(Clk), .Reset_n(Reset_n), .In_valid(in_valid0), .In_ready(in_ready0),
        .D(d0), .SDO(sdo0), .Frame(frame0), .Done(done0)
    );

    mu0_reg16_serial_out #(.WIDTH(16), .DIV(1), .MSB_FIRST(1)) dut1 (
        .Clk(Clk), .Reset_n(Reset_n), .In_valid(in_valid1), .In_ready(in_ready1),
        .D(d1), .SDO(sdo1), .Frame(frame1), .Done(done1)
    );

    mu0_reg16_serial_out #(.WIDTH(16), .DIV(2), .MSB_FIRST(0)) dut2 (
        .Clk(Clk), .Reset_n(Reset_n), .In_valid(in_valid2), .In_ready(in_ready2),
        .D(d2), .SDO(sdo2), .Frame(frame2), .Done(done2)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Called just after the capture edge E0 of dut0; leaves the bench just after E0+65.
    task automatic run_frame0(input logic [15:0] w, input string tag);
        for (int c = 0; c < 64; c++) begin
            chk({tag, " sdo"}, sdo0, w[15 - c / 4]);
            chk({tag, " frame"}, frame0, 1'b1);
            if (c == 0) begin
                chk({tag, " ready_in_shift"}, in_ready0, 1'b0);
                chk({tag, " done_in_shift"}, done0, 1'b0);
            end
            step();
        end
        chk({tag, " done_pulse"}, done0, 1'b1);
        chk({tag, " frame_end"}, frame0, 1'b0);
        chk({tag, " sdo_end"}, sdo0, 1'b0);
        chk({tag, " ready_in_done"}, in_ready0, 1'b0);
        step();
        chk({tag, " done_one_cycle"}, done0, 1'b0);
        chk({tag, " ready_back"}, in_ready0, 1'b1);
    endtask

    initial begin
        Reset_n   = 1'b0;
        in_valid0 = 1'b1;  d0 = 16'hFFFF;
        in_valid1 = 1'b0;  d1 = 16'h0000;
        in_valid2 = 1'b0;  d2 = 16'h0000;

        // Reset held with a valid word offered: nothing may be captured.
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst sdo", sdo0, 1'b0);
            chk("rst frame", frame0, 1'b0);
            chk("rst done", done0, 1'b0);
            chk("rst ready", in_ready0, 1'b1);
            step();
        end
        chk("rst ready dut1", in_ready1, 1'b1);
        chk("rst ready dut2", in_ready2, 1'b1);

        // A5C3, DIV=4, MSB first.
        d0 = 16'hA5C3;
        Reset_n = 1'b1;
        step();
        in_valid0 = 1'b0;
        run_frame0(16'hA5C3, "a5c3");

        // In_valid held high; D changes after capture.
        in_valid0 = 1'b1;
        d0 = 16'h1234;
        step();
        d0 = 16'h5678;
        run_frame0(16'h1234, "1234");
        step();
        chk("5678 captured", frame0, 1'b1);
        in_valid0 = 1'b0;
        run_frame0(16'h5678, "5678");

        // Reset during word bit 7 of 00FF (sent during cycles 32..35).
        in_valid0 = 1'b1;
        d0 = 16'h00FF;
        step();
        in_valid0 = 1'b0;
        for (int c = 0; c < 34; c++) begin
            chk("00ff sdo", sdo0, c >= 32);
            if (c < 33) step();
        end
        Reset_n = 1'b0;
        #1;
        chk("abort sdo", sdo0, 1'b0);
        chk("abort frame", frame0, 1'b0);
        chk("abort ready", in_ready0, 1'b1);
        step();
        chk("abort no_done", done0, 1'b0);
        chk("abort frame_held", frame0, 1'b0);
        Reset_n = 1'b1;
        d0 = 16'hFFFF;
        in_valid0 = 1'b1;
        step();
        in_valid0 = 1'b0;
        run_frame0(16'hFFFF, "ffff");

        // DIV=1: 8001 in 16 cycles, Done at E0+16.
        in_valid1 = 1'b1;
        d1 = 16'h8001;
        step();
        in_valid1 = 1'b0;
        for (int c = 0; c < 16; c++) begin
            chk("div1 sdo", sdo1, (c == 0) || (c == 15));
            chk("div1 frame", frame1, 1'b1);
            step();
        end
        chk("div1 done", done1, 1'b1);
        chk("div1 frame_end", frame1, 1'b0);
        step();
        chk("div1 done_one_cycle", done1, 1'b0);
        chk("div1 ready", in_ready1, 1'b1);

        // LSB first, DIV=2: 0001 gives 1 for two cycles then 0 for thirty.
        in_valid2 = 1'b1;
        d2 = 16'h0001;
        step();
        in_valid2 = 1'b0;
        for (int c = 0; c < 32; c++) begin
            chk("lsb sdo", sdo2, c < 2);
            chk("lsb frame", frame2, 1'b1);
            step();
        end
        chk("lsb done", done2, 1'b1);
        chk("lsb frame_end", frame2, 1'b0);
        step();
        chk("lsb done_one_cycle", done2, 1'b0);
        chk("lsb ready", in_ready2, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
